// File: rtl/food_target_gen_pkg.sv
// food_target_gen_pkg: shared game-state encodings, grid defaults and FSM type
package food_target_gen_pkg;
    localparam logic [1:0] MS_IDLE = 2'd0;
    localparam logic [1:0] MS_PLAY = 2'd1;
    localparam logic [1:0] MS_WIN  = 2'd2;
    localparam int GRID_H_DEF = 160;
    localparam int GRID_V_DEF = 120;
    typedef enum logic {HOLD, GEN} fsm_t;
endpackage

// File: rtl/food_target_gen_lfsr_gen.sv
// lfsr_gen: free-running Fibonacci LFSR, left shift, feedback is XOR of tapped bits
module lfsr_gen #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = '1,
    parameter logic [WIDTH-1:0] SEED = '1
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic [WIDTH-1:0] Q
);
    logic [WIDTH-1:0] q_q, q_d;
    always_comb q_d = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
    always_ff @(posedge CLK) q_q <= RESET ? SEED : q_d;
    assign Q = q_q;
endmodule

// File: rtl/food_target_gen.sv
// food_target_gen: picks a new in-range food cell on each reach, LFSR rejection sampling with bounded fallback
module food_target_gen
    import food_target_gen_pkg::*;
#(
    parameter int GRID_H = GRID_H_DEF,
    parameter int GRID_V = GRID_V_DEF,
    parameter int H_W = 8,
    parameter int V_W = 7,
    parameter int MAX_TRIES = 8,
    parameter int RESET_H = 80,
    parameter int RESET_V = 60,
    parameter logic [H_W-1:0] SEED_H = 8'hA5,
    parameter logic [V_W-1:0] SEED_V = 7'h4B,
    parameter logic [H_W-1:0] H_TAPS = 8'hB8,
    parameter logic [V_W-1:0] V_TAPS = 7'h60
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [1:0]     MASTER_STATE,
    input  logic           TARGET_REACHED,
    output logic [H_W-1:0] ADDRH,
    output logic [V_W-1:0] ADDRV,
    output logic           TARGET_VALID
);
    localparam int TW = MAX_TRIES > 1 ? $clog2(MAX_TRIES) : 1;
    localparam logic [TW-1:0] LAST = TW'(MAX_TRIES - 1);
    localparam logic [H_W-1:0] GH = H_W'(GRID_H);
    localparam logic [H_W-1:0] GH_M1 = H_W'(GRID_H - 1);
    localparam logic [V_W-1:0] GV = V_W'(GRID_V);
    logic [H_W-1:0] lfsr_h, addrh_q, addrh_d, fh_raw, fh;
    logic [V_W-1:0] lfsr_v, addrv_q, addrv_d, fv;
    logic [TW-1:0] tries_q, tries_d;
    logic valid_q, valid_d, start, gen, accept, done;
    fsm_t state_q, state_d;

    lfsr_gen #(.WIDTH(H_W), .TAPS(H_TAPS), .SEED(SEED_H)) u_lfsr_h (.CLK(CLK), .RESET(RESET), .Q(lfsr_h));
    lfsr_gen #(.WIDTH(V_W), .TAPS(V_TAPS), .SEED(SEED_V)) u_lfsr_v (.CLK(CLK), .RESET(RESET), .Q(lfsr_v));

    always_comb begin
        fh_raw  = lfsr_h >= GH ? lfsr_h - GH : lfsr_h;
        fv      = lfsr_v >= GV ? lfsr_v - GV : lfsr_v;
        fh      = (fh_raw == addrh_q && fv == addrv_q) ? (fh_raw == GH_M1 ? '0 : fh_raw + 1'b1) : fh_raw;
        accept  = lfsr_h < GH && lfsr_v < GV && !(lfsr_h == addrh_q && lfsr_v == addrv_q);
        done    = accept || tries_q == LAST;
        start   = state_q == HOLD && TARGET_REACHED && MASTER_STATE == MS_PLAY;
        gen     = state_q == GEN;
        state_d = start ? GEN : (gen && done) ? HOLD : state_q;
        valid_d = start ? 1'b0 : (gen && done) ? 1'b1 : valid_q;
        tries_d = (gen && !done) ? tries_q + 1'b1 : '0;
        addrh_d = (gen && done) ? (accept ? lfsr_h : fh) : addrh_q;
        addrv_d = (gen && done) ? (accept ? lfsr_v : fv) : addrv_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= HOLD;
            tries_q <= '0;
            addrh_q <= H_W'(RESET_H);
            addrv_q <= V_W'(RESET_V);
            valid_q <= 1'b1;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            addrh_q <= addrh_d;
            addrv_q <= addrv_d;
            valid_q <= valid_d;
        end
    end

    assign ADDRH = addrh_q;
    assign ADDRV = addrv_q;
    assign TARGET_VALID = valid_q;
endmodule

// File: tb/tb_food_target_gen.sv
// tb_food_target_gen: directed scenarios against a reference LFSR model plus a small-grid fallback instance
module tb_food_target_gen;
    logic clk = 1'b0, rst = 1'b1, tr = 1'b0, tr_s = 1'b0;
    logic [1:0] ms = 2'd0;
    logic [7:0] addrh;
    logic [6:0] addrv;
    logic valid;
    logic [3:0] addrh_s;
    logic [2:0] addrv_s;
    logic valid_s;
    int n_chk = 0, n_fail = 0;
    logic [7:0] exp_h = 8'd80, m_h;
    logic [6:0] exp_v = 7'd60, m_v;

    food_target_gen dut (.CLK(clk), .RESET(rst), .MASTER_STATE(ms), .TARGET_REACHED(tr),
                         .ADDRH(addrh), .ADDRV(addrv), .TARGET_VALID(valid));

    food_target_gen #(.GRID_H(8), .GRID_V(4), .H_W(4), .V_W(3), .MAX_TRIES(1), .RESET_H(4), .RESET_V(2),
                      .SEED_H(4'h5), .SEED_V(3'h3), .H_TAPS(4'hC), .V_TAPS(3'h6)) dut_s (
        .CLK(clk), .RESET(rst), .MASTER_STATE(ms), .TARGET_REACHED(tr_s),
        .ADDRH(addrh_s), .ADDRV(addrv_s), .TARGET_VALID(valid_s));

    always #5 clk = ~clk;

    function automatic logic [7:0] step_h(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic logic [6:0] step_v(input logic [6:0] x);
        return {x[5:0], x[6] ^ x[5]};
    endfunction

    always @(posedge clk) begin
        m_h <= rst ? 8'hA5 : step_h(m_h);
        m_v <= rst ? 7'h4B : step_v(m_v);
    end

    task automatic predict(input logic [7:0] h0, input logic [6:0] v0,
                           output logic [7:0] ph, output logic [6:0] pv, output int lat);
        logic [7:0] h, fh;
        logic [6:0] v, fv;
        h = h0; v = v0; lat = 0; ph = exp_h; pv = exp_v;
        for (int t = 0; t < 8 && lat == 0; t++) begin
            if (h < 8'd160 && v < 7'd120 && !(h == exp_h && v == exp_v)) begin
                ph = h; pv = v; lat = t + 1;
            end else if (t == 7) begin
                fh = h >= 8'd160 ? h - 8'd160 : h;
                fv = v >= 7'd120 ? v - 7'd120 : v;
                if (fh == exp_h && fv == exp_v) fh = fh == 8'd159 ? 8'd0 : fh + 8'd1;
                ph = fh; pv = fv; lat = 8;
            end
            h = step_h(h);
            v = step_v(v);
        end
    endtask

    task automatic reach(input int extra);
        logic [7:0] ph;
        logic [6:0] pv;
        int lat, sent;
        @(negedge clk); ms = 2'd1; tr = 1'b1;
        @(negedge clk);
        predict(m_h, m_v, ph, pv, lat);
        sent = extra > 0 ? 1 : 0;
        tr = extra > 0;
        n_chk++;
        if ({valid, addrh, addrv} !== {1'b0, exp_h, exp_v}) begin
            n_fail++;
            $display("FAIL gen_entry: got valid=%0b h=%0d v=%0d, expected valid=0 h=%0d v=%0d", valid, addrh, addrv, exp_h, exp_v);
        end
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            tr = (i < lat && sent < extra);
            if (tr) sent++;
            n_chk++;
            if (i < lat) begin
                if ({valid, addrh, addrv} !== {1'b0, exp_h, exp_v}) begin
                    n_fail++;
                    $display("FAIL gen_hold: cycle %0d got valid=%0b h=%0d v=%0d, expected valid=0 h=%0d v=%0d", i, valid, addrh, addrv, exp_h, exp_v);
                end
            end else if ({valid, addrh, addrv} !== {1'b1, ph, pv}) begin
                n_fail++;
                $display("FAIL new_target: latency %0d got valid=%0b h=%0d v=%0d, expected valid=1 h=%0d v=%0d", lat, valid, addrh, addrv, ph, pv);
            end
        end
        exp_h = ph;
        exp_v = pv;
    endtask

    task automatic test_reset();
        rst = 1'b1; ms = 2'd0; tr = 1'b0; tr_s = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        exp_h = 8'd80; exp_v = 7'd60;
        repeat (5) begin
            @(negedge clk);
            n_chk++;
            if ({valid, addrh, addrv} !== {1'b1, 8'd80, 7'd60}) begin
                n_fail++;
                $display("FAIL reset_state: got valid=%0b h=%0d v=%0d, expected valid=1 h=80 v=60", valid, addrh, addrv);
            end
        end
    endtask

    task automatic test_play();
        reach(0);
        n_chk++;
        if (!(addrh < 8'd160 && addrv < 7'd120 && {addrh, addrv} != {8'd80, 7'd60})) begin
            n_fail++;
            $display("FAIL first_target_legal: got h=%0d v=%0d, required h<160 v<120 and not (80,60)", addrh, addrv);
        end
        reach(0);
        reach(0);
    endtask

    task automatic test_freeze();
        logic [1:0] states [3] = '{2'd0, 2'd2, 2'd3};
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); ms = states[s]; tr = 1'b1;
            @(negedge clk); tr = 1'b0;
            repeat (3) begin
                @(negedge clk);
                n_chk++;
                if ({valid, addrh, addrv} !== {1'b1, exp_h, exp_v}) begin
                    n_fail++;
                    $display("FAIL freeze_ms%0d: got valid=%0b h=%0d v=%0d, expected valid=1 h=%0d v=%0d", states[s], valid, addrh, addrv, exp_h, exp_v);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        reach(2);
        tr = 1'b0;
        repeat (4) begin
            @(negedge clk);
            n_chk++;
            if ({valid, addrh, addrv} !== {1'b1, exp_h, exp_v}) begin
                n_fail++;
                $display("FAIL no_requeue: got valid=%0b h=%0d v=%0d, expected valid=1 h=%0d v=%0d", valid, addrh, addrv, exp_h, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_gen();
        @(negedge clk); ms = 2'd1; tr = 1'b1;
        @(negedge clk); tr = 1'b0; rst = 1'b1;
        n_chk++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_gen_entry: got valid=%0b, expected 0", valid);
        end
        @(negedge clk); rst = 1'b0;
        exp_h = 8'd80; exp_v = 7'd60;
        repeat (2) begin
            n_chk++;
            if ({valid, addrh, addrv} !== {1'b1, 8'd80, 7'd60}) begin
                n_fail++;
                $display("FAIL mid_gen_reset: got valid=%0b h=%0d v=%0d, expected valid=1 h=80 v=60", valid, addrh, addrv);
            end
            @(negedge clk);
        end
        reach(0);
    endtask

    task automatic test_fallback();
        logic [3:0] ph = 4'd4;
        logic [2:0] pv = 3'd2;
        ms = 2'd1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk); tr_s = 1'b1;
            @(negedge clk); tr_s = 1'b0;
            n_chk++;
            if (valid_s !== 1'b0) begin
                n_fail++;
                $display("FAIL fb_gen_entry: pulse %0d got valid=%0b, expected 0", k, valid_s);
            end
            @(negedge clk);
            n_chk++;
            if (!(valid_s === 1'b1 && addrh_s < 4'd8 && addrv_s < 3'd4 && {addrh_s, addrv_s} != {ph, pv})) begin
                n_fail++;
                $display("FAIL fb_target: pulse %0d got valid=%0b h=%0d v=%0d, required valid=1 h<8 v<4 differing from (%0d,%0d)", k, valid_s, addrh_s, addrv_s, ph, pv);
            end
            ph = addrh_s;
            pv = addrv_s;
        end
    endtask

    initial begin
        test_reset();
        test_play();
        test_freeze();
        test_back_to_back();
        test_reset_mid_gen();
        test_fallback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
